// File: rtl/game_move_seq.sv
// Paced sequencer that steps the combinational man-move stage toward a cursor target.
// Build option: define GAME_MOVE_UNDO_EN to add undo_i and a one-level state snapshot.
module game_move_seq #(
    parameter int STEP_DIV  = 4,
    parameter int MAX_STEPS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [133:0]     level_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [5:0]       cmd_cursor_i,
`ifdef GAME_MOVE_UNDO_EN
    input  logic             undo_i,
`endif
    output logic [133:0]     mm_state_o,
    output logic [5:0]       mm_cursor_o,
    input  logic [133:0]     mm_state_next_i,
    input  logic             mm_result_i,
    output logic [133:0]     state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             blocked_o,
    output logic [CNT_W-1:0] move_cnt_o
);

    localparam int STATE_W = 134;
    localparam int STEP_W  = $clog2(MAX_STEPS + 1);
    localparam int PACE_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_FIN
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [5:0]         cursor_q, cursor_d;
    logic [CNT_W-1:0]   move_cnt_q, move_cnt_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [STEP_W-1:0]  step_inc;
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic               fin_done_q, fin_done_d;   // 1: FIN reports done, 0: blocked
`ifdef GAME_MOVE_UNDO_EN
    logic [STATE_W-1:0] snap_q, snap_d;
    logic               snap_vld_q, snap_vld_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            state_q    <= '0;
            cursor_q   <= '0;
            move_cnt_q <= '0;
            step_cnt_q <= '0;
            pace_q     <= '0;
            fin_done_q <= 1'b0;
`ifdef GAME_MOVE_UNDO_EN
            snap_vld_q <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            move_cnt_q <= move_cnt_d;
            step_cnt_q <= step_cnt_d;
            pace_q     <= pace_d;
            fin_done_q <= fin_done_d;
`ifdef GAME_MOVE_UNDO_EN
            snap_vld_q <= snap_vld_d;
`endif
        end
    end

`ifdef GAME_MOVE_UNDO_EN
    // NOTE: the snapshot data needs no reset; snap_vld_q gates every use of it.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end
`endif

    // Next-state and datapath update
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        cursor_d   = cursor_q;
        move_cnt_d = move_cnt_q;
        step_cnt_d = step_cnt_q;
        pace_d     = pace_q;
        fin_done_d = fin_done_q;
        step_inc   = step_cnt_q + 1'b1;
`ifdef GAME_MOVE_UNDO_EN
        snap_d     = snap_q;
        snap_vld_d = snap_vld_q;
`endif

        unique case (fsm_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cursor_d   = cmd_cursor_i;
                    step_cnt_d = '0;
                    pace_d     = '0;
`ifdef GAME_MOVE_UNDO_EN
                    snap_d     = state_q;
                    snap_vld_d = 1'b1;
`endif
                    if (cmd_cursor_i == state_q[5:0]) begin
                        fsm_d      = S_FIN;
                        fin_done_d = 1'b1;
                    end else begin
                        fsm_d = S_STEP;
                    end
                end
`ifdef GAME_MOVE_UNDO_EN
                // A command in the same cycle wins; the undo is dropped.
                else if (undo_i && snap_vld_q) begin
                    state_d    = snap_q;
                    move_cnt_d = move_cnt_q - CNT_W'(step_cnt_q);
                    snap_vld_d = 1'b0;
                end
`endif
            end

            S_STEP: begin
                if (mm_result_i) begin
                    state_d    = mm_state_next_i;
                    move_cnt_d = move_cnt_q + 1'b1;
                    step_cnt_d = step_inc;
                    pace_d     = '0;
                    if (mm_state_next_i[5:0] == cursor_q) begin
                        fsm_d      = S_FIN;
                        fin_done_d = 1'b1;
                    end else if (int'(step_inc) == MAX_STEPS) begin
                        fsm_d      = S_FIN;
                        fin_done_d = 1'b0;
                    end else if (STEP_DIV == 1) begin
                        fsm_d = S_STEP;
                    end else begin
                        fsm_d = S_WAIT;
                    end
                end else begin
                    fsm_d      = S_FIN;
                    fin_done_d = 1'b0;
                end
            end

            S_WAIT: begin
                // WAIT lasts STEP_DIV-1 cycles so each step costs STEP_DIV cycles.
                if (int'(pace_q) >= STEP_DIV - 2) begin
                    fsm_d = S_STEP;
                end else begin
                    pace_d = pace_q + 1'b1;
                end
            end

            S_FIN: begin
                fsm_d = S_IDLE;
            end
        endcase

        if (load_i) begin
            fsm_d      = S_IDLE;
            state_d    = level_i;
            move_cnt_d = '0;
            step_cnt_d = '0;
            pace_d     = '0;
`ifdef GAME_MOVE_UNDO_EN
            snap_vld_d = 1'b0;
`endif
        end
    end

    // Outputs
    always_comb begin
        cmd_ready_o = (fsm_q == S_IDLE);
        busy_o      = (fsm_q != S_IDLE);
        done_o      = (fsm_q == S_FIN) && fin_done_q;
        blocked_o   = (fsm_q == S_FIN) && !fin_done_q;
        state_o     = state_q;
        mm_state_o  = state_q;
        mm_cursor_o = cursor_q;
        move_cnt_o  = move_cnt_q;
    end

endmodule

// File: tb/tb_game_move_seq.sv
// Bench for game_move_seq: two instances (STEP_DIV=4/MAX_STEPS=64 and STEP_DIV=1/MAX_STEPS=3)
// driven in lockstep, each fed by a behavioural move stage and checked against a command-level model.
module tb_game_move_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [133:0] level;
    logic         cmd_valid;
    logic [5:0]   cmd_cursor;
`ifdef GAME_MOVE_UNDO_EN
    logic         undo;
`endif

    logic [133:0] st_o [2];
    logic [133:0] mm_st [2];
    logic [5:0]   mm_cur [2];
    logic [134:0] ms_out [2];
    logic         ready [2];
    logic         busy [2];
    logic         done [2];
    logic         blocked [2];
    logic [15:0]  cnt [2];

    logic [133:0] exp_st [2];
    logic [133:0] snap [2];
    logic [15:0]  exp_cnt [2];
    bit           snap_vld [2];
    int           last_steps [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural move stage: one cell toward the cursor, column first; a map bit is a wall.
    // A legal step also toggles the box bit of the entered cell so box data is exercised.
    function automatic logic [134:0] move_stage(input logic [133:0] st, input logic [5:0] cur);
        int r, c, tr, tc;
        logic [5:0]   np;
        logic [133:0] ns;
        r  = int'(st[5:3]);
        c  = int'(st[2:0]);
        tr = int'(cur[5:3]);
        tc = int'(cur[2:0]);
        if (c != tc) c = c + ((tc > c) ? 1 : -1);
        else if (r != tr) r = r + ((tr > r) ? 1 : -1);
        np = 6'(r * 8 + c);
        if (st[70 + int'(np)]) return {1'b0, st};
        ns = st;
        ns[5:0] = np;
        ns[6 + int'(np)] = ~ns[6 + int'(np)];
        return {1'b1, ns};
    endfunction

    // Whole-command outcome: final state, accepted steps, number of STEP visits, done(1)/blocked(0).
    function automatic void ref_cmd(input logic [133:0] st, input logic [5:0] cur, input int max_steps,
                                    output logic [133:0] f_st, output int steps, output int visits,
                                    output bit ok);
        logic [134:0] r;
        bit stop;
        f_st = st; steps = 0; visits = 0; ok = 1'b1;
        stop = (st[5:0] == cur);
        while (!stop) begin
            visits++;
            r = move_stage(f_st, cur);
            if (!r[134]) begin
                ok = 1'b0; stop = 1'b1;
            end else begin
                f_st = r[133:0];
                steps++;
                if (f_st[5:0] == cur) stop = 1'b1;
                else if (steps == max_steps) begin ok = 1'b0; stop = 1'b1; end
            end
        end
    endfunction

    function automatic int max_of(input int i); return (i == 0) ? 64 : 3; endfunction
    function automatic int div_of(input int i); return (i == 0) ? 4 : 1; endfunction

    assign ms_out[0] = move_stage(mm_st[0], mm_cur[0]);
    assign ms_out[1] = move_stage(mm_st[1], mm_cur[1]);

    game_move_seq #(.STEP_DIV(4), .MAX_STEPS(64), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .load_i(load), .level_i(level),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(ready[0]), .cmd_cursor_i(cmd_cursor),
`ifdef GAME_MOVE_UNDO_EN
        .undo_i(undo),
`endif
        .mm_state_o(mm_st[0]), .mm_cursor_o(mm_cur[0]),
        .mm_state_next_i(ms_out[0][133:0]), .mm_result_i(ms_out[0][134]),
        .state_o(st_o[0]), .busy_o(busy[0]), .done_o(done[0]), .blocked_o(blocked[0]),
        .move_cnt_o(cnt[0])
    );

    game_move_seq #(.STEP_DIV(1), .MAX_STEPS(3), .CNT_W(16)) u_dut_fast (
        .clk(clk), .rst(rst), .load_i(load), .level_i(level),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(ready[1]), .cmd_cursor_i(cmd_cursor),
`ifdef GAME_MOVE_UNDO_EN
        .undo_i(undo),
`endif
        .mm_state_o(mm_st[1]), .mm_cursor_o(mm_cur[1]),
        .mm_state_next_i(ms_out[1][133:0]), .mm_result_i(ms_out[1][134]),
        .state_o(st_o[1]), .busy_o(busy[1]), .done_o(done[1]), .blocked_o(blocked[1]),
        .move_cnt_o(cnt[1])
    );

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({ready[i], busy[i], done[i], blocked[i]} !== 4'b1000) begin
                n_err++;
                $display("FAIL %s_idle[%0d]: ready/busy/done/blocked=%b want 1000", tag, i,
                         {ready[i], busy[i], done[i], blocked[i]});
            end
            n_cmp++;
            if (st_o[i] !== exp_st[i] || mm_st[i] !== exp_st[i]) begin
                n_err++;
                $display("FAIL %s_state[%0d]: got %h want %h", tag, i, st_o[i], exp_st[i]);
            end
            n_cmp++;
            if (cnt[i] !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL %s_cnt[%0d]: got %0d want %0d", tag, i, cnt[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic do_load(input logic [133:0] lv);
        level = lv;
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_st[i] = lv; exp_cnt[i] = '0; snap_vld[i] = 1'b0;
        end
        check_idle("load");
    endtask

    task automatic run_cmd(input logic [5:0] cur, input bit noise);
        logic [133:0] f_st [2];
        int  f_steps [2];
        int  lat [2];
        bit  f_ok [2];
        bit  fin [2];
        int  visits;
        for (int i = 0; i < 2; i++) begin
            ref_cmd(exp_st[i], cur, max_of(i), f_st[i], f_steps[i], visits, f_ok[i]);
            lat[i] = (visits == 0) ? 1 : 1 + div_of(i) * (visits - 1) + 1;
            fin[i] = 1'b0;
            n_cmp++;
            if (ready[i] !== 1'b1) begin
                n_err++;
                $display("FAIL cmd_ready[%0d]: got %b want 1", i, ready[i]);
            end
        end
        cmd_valid  = 1'b1;
        cmd_cursor = cur;
        @(posedge clk); #1;
        cmd_valid  = noise;
        cmd_cursor = 6'($urandom);
        for (int c = 1; c <= 400 && !(fin[0] && fin[1]); c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!fin[i] && (done[i] === 1'b1 || blocked[i] === 1'b1 || c > lat[i])) begin
                    fin[i]    = 1'b1;
                    cmd_valid = 1'b0;
                    n_cmp++;
                    if (c != lat[i]) begin
                        n_err++;
                        $display("FAIL latency[%0d]: pulse at cycle %0d want %0d", i, c, lat[i]);
                    end
                    n_cmp++;
                    if ({done[i], blocked[i]} !== {f_ok[i], !f_ok[i]}) begin
                        n_err++;
                        $display("FAIL outcome[%0d]: done/blocked=%b%b want %b%b", i, done[i],
                                 blocked[i], f_ok[i], !f_ok[i]);
                    end
                    n_cmp++;
                    if (mm_cur[i] !== cur) begin
                        n_err++;
                        $display("FAIL mm_cursor[%0d]: got %o want %o", i, mm_cur[i], cur);
                    end
                    snap[i]       = exp_st[i];
                    snap_vld[i]   = 1'b1;
                    last_steps[i] = f_steps[i];
                    exp_st[i]     = f_st[i];
                    exp_cnt[i]    = exp_cnt[i] + 16'(f_steps[i]);
                    n_cmp++;
                    if (st_o[i] !== exp_st[i] || cnt[i] !== exp_cnt[i]) begin
                        n_err++;
                        $display("FAIL result[%0d]: state %h cnt %0d want %h cnt %0d", i, st_o[i],
                                 cnt[i], exp_st[i], exp_cnt[i]);
                    end
                end
            end
            if (!(fin[0] && fin[1])) begin
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_idle("post_cmd");
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_st[i] = '0; exp_cnt[i] = '0; snap_vld[i] = 1'b0;
            n_cmp++;
            if (mm_cur[i] !== 6'o00) begin
                n_err++;
                $display("FAIL reset_cursor[%0d]: got %o want 0", i, mm_cur[i]);
            end
        end
        check_idle("reset");
    endtask

    task automatic test_walk;
        do_load({64'h0, {$urandom, $urandom}, 6'o11});
        run_cmd(6'o17, 1'b1);
        n_cmp++;
        if (st_o[0][5:0] !== 6'o17 || cnt[0] !== 16'd6) begin
            n_err++;
            $display("FAIL walk_slow: pos %o cnt %0d want 17 cnt 6", st_o[0][5:0], cnt[0]);
        end
        n_cmp++;
        if (st_o[1][5:0] !== 6'o14 || cnt[1] !== 16'd3) begin
            n_err++;
            $display("FAIL walk_max_steps: pos %o cnt %0d want 14 cnt 3", st_o[1][5:0], cnt[1]);
        end
    endtask

    task automatic test_at_cursor;
        do_load({64'h0, {$urandom, $urandom}, 6'o11});
        run_cmd(6'o11, 1'b0);
        n_cmp++;
        if (cnt[0] !== 16'd0 || st_o[0][5:0] !== 6'o11) begin
            n_err++;
            $display("FAIL at_cursor: pos %o cnt %0d want 11 cnt 0", st_o[0][5:0], cnt[0]);
        end
    endtask

    task automatic test_wall;
        logic [63:0] map;
        map = 64'h1 << 11;
        do_load({map, 64'h0, 6'o11});
        run_cmd(6'o15, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (st_o[i][5:0] !== 6'o12 || cnt[i] !== 16'd1) begin
                n_err++;
                $display("FAIL wall[%0d]: pos %o cnt %0d want 12 cnt 1", i, st_o[i][5:0], cnt[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] map;
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0) begin
                map = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                do_load({map, {$urandom, $urandom}, 6'($urandom)});
            end
            run_cmd(6'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_load_abort;
        logic [133:0] lv2;
        do_load({64'h0, 64'h0, 6'o11});
        cmd_valid  = 1'b1;
        cmd_cursor = 6'o17;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy: busy=%b%b want 11", busy[0], busy[1]);
        end
        lv2 = {64'h0, {$urandom, $urandom}, 6'o33};
        level = lv2;
        load = 1'b1;
        cmd_valid = 1'b1;
        cmd_cursor = 6'o35;
        @(posedge clk); #1;
        load = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_st[i] = lv2; exp_cnt[i] = '0; snap_vld[i] = 1'b0;
        end
        check_idle("load_abort");
        @(posedge clk); #1;
        check_idle("load_abort_hold");
    endtask

    task automatic test_reset_abort;
        do_load({64'h0, {$urandom, $urandom}, 6'o00});
        cmd_valid  = 1'b1;
        cmd_cursor = 6'o77;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
    endtask

`ifdef GAME_MOVE_UNDO_EN
    task automatic do_undo;
        undo = 1'b1;
        @(posedge clk); #1;
        undo = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (snap_vld[i]) begin
                exp_st[i]   = snap[i];
                exp_cnt[i]  = exp_cnt[i] - 16'(last_steps[i]);
                snap_vld[i] = 1'b0;
            end
        end
        check_idle("undo");
    endtask

    task automatic test_undo;
        do_load({64'h0, {$urandom, $urandom}, 6'o11});
        run_cmd(6'o17, 1'b0);
        do_undo();
        n_cmp++;
        if (st_o[0][5:0] !== 6'o11 || cnt[0] !== 16'd0) begin
            n_err++;
            $display("FAIL undo_restore: pos %o cnt %0d want 11 cnt 0", st_o[0][5:0], cnt[0]);
        end
        do_undo();
        run_cmd(6'o13, 1'b0);
        do_load({64'h0, 64'h0, 6'o22});
        do_undo();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; level = '0; cmd_valid = 1'b0; cmd_cursor = '0;
`ifdef GAME_MOVE_UNDO_EN
        undo = 1'b0;
`endif
        test_reset();
        test_walk();
        test_at_cursor();
        test_wall();
        test_random();
        test_load_abort();
        test_reset_abort();
`ifdef GAME_MOVE_UNDO_EN
        test_undo();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
